hsv_sweep_ctrl: RTL

HSV_SWEEP_CTRL -- requirements
Module: hsv_sweep_ctrl

---
 rtl/hsv_pkg.sv | 41 ++++
 rtl/hsv_tick_gen.sv | 37 +++
 rtl/hsv_sweep_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/hsv_pkg.sv
// Shared encodings and constants for the HSV sweep controller.
package hsv_pkg;

    localparam int unsigned HUE_MAX = 359;
    localparam int unsigned PCT_MAX = 100;

    typedef enum logic [1:0] {
        ModeHue     = 2'd0,
        ModeBreathe = 2'd1,
        ModeSat     = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StIssue   = 2'd1,
        StWait    = 2'd2,
        StCapture = 2'd3
    } state_t;

    // Hue addition wrapping modulo 360 (step is always below 360).
    function automatic logic [8:0] hue_add(input logic [8:0] h, input logic [8:0] step);
        logic [9:0] s;
        s = {1'b0, h} + {1'b0, step};
        if (s > 10'(HUE_MAX)) begin
            s = s - 10'(HUE_MAX + 1);
        end
        return s[8:0];
    endfunction

    // Mode rotation HUE -> BREATHE -> SAT -> HUE.
    function automatic mode_t next_mode(input mode_t m);
        mode_t n;
        case (m)
            ModeHue:     n = ModeBreathe;
            ModeBreathe: n = ModeSat;
            default:     n = ModeHue;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/hsv_tick_gen.sv
// Sweep prescaler: counts 0..CLK_DIV-1 while enabled, one-cycle tick on wrap.
module hsv_tick_gen #(
    parameter int unsigned CLK_DIV = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q;

    // Prescaler count; freezes when disabled, clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else if (clr) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (en) begin
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    cnt_q <= '0;
                    tick  <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hsv_sweep_ctrl.sv
// HSV colour sweep sequencer: issues HSV words to an external converter on
// each prescaler tick, waits its latency and captures the RGB result.
module hsv_sweep_ctrl
    import hsv_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 1000000,
    parameter int unsigned HUE_STEP = 1,
    parameter int unsigned CONV_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_run,
    input  logic       btn_mode,
    output logic [8:0] hue,
    output logic [8:0] sat,
    output logic [8:0] val,
    output logic       hsv_valid,
    input  logic [7:0] conv_r,
    input  logic [7:0] conv_g,
    input  logic [7:0] conv_b,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic       rgb_valid,
    output logic       changed,
    output logic [1:0] mode,
    output logic       running
);

    state_t     state_q;
    mode_t      mode_q;
    logic [3:0] wait_cnt_q;
    logic       run_prev_q, mode_prev_q;
    logic       run_pend_q, mode_pend_q;
    logic [6:0] sat_ramp_q;
    logic       breathe_down_q;
    logic       tick;
    logic       in_idle;
    logic       run_edge, mode_edge;
    logic [8:0] val_step;

    assign in_idle   = (state_q == StIdle);
    assign run_edge  = btn_run & ~run_prev_q;
    assign mode_edge = btn_mode & ~mode_prev_q;
    assign val_step  = breathe_down_q ? (val - 9'd1) : (val + 9'd1);
    assign mode      = mode_q;

    hsv_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (running),
        .clr  (in_idle & mode_pend_q),
        .tick (tick)
    );

    // Button edge detection; edges stay pending until the FSM is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_prev_q  <= 1'b0;
            mode_prev_q <= 1'b0;
            run_pend_q  <= 1'b0;
            mode_pend_q <= 1'b0;
        end else begin
            run_prev_q  <= btn_run;
            mode_prev_q <= btn_mode;
            run_pend_q  <= (run_pend_q & ~in_idle) | run_edge;
            mode_pend_q <= (mode_pend_q & ~in_idle) | mode_edge;
        end
    end

    // Sequencer FSM with registered HSV/RGB outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            mode_q         <= ModeHue;
            running        <= 1'b1;
            wait_cnt_q     <= '0;
            hue            <= '0;
            sat            <= 9'(PCT_MAX);
            val            <= 9'(PCT_MAX);
            hsv_valid      <= 1'b0;
            r              <= '0;
            g              <= '0;
            b              <= '0;
            rgb_valid      <= 1'b0;
            changed        <= 1'b0;
            sat_ramp_q     <= '0;
            breathe_down_q <= 1'b1;
        end else begin
            hsv_valid <= 1'b0;
            rgb_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Pending button actions win over a coincident tick.
                    if (run_pend_q || mode_pend_q) begin
                        if (run_pend_q) begin
                            running <= ~running;
                        end
                        if (mode_pend_q) begin
                            mode_q         <= next_mode(mode_q);
                            breathe_down_q <= 1'b1;
                            sat_ramp_q     <= '0;
                        end
                    end else if (tick && running) begin
                        state_q   <= StIssue;
                        hsv_valid <= 1'b1;
                        unique case (mode_q)
                            ModeHue: begin
                                hue <= hue_add(hue, 9'(HUE_STEP));
                                sat <= 9'(PCT_MAX);
                                val <= 9'(PCT_MAX);
                            end
                            ModeBreathe: begin
                                sat <= 9'(PCT_MAX);
                                val <= val_step;
                                if (val_step == 9'd0) begin
                                    breathe_down_q <= 1'b0;
                                end else if (val_step == 9'(PCT_MAX)) begin
                                    breathe_down_q <= 1'b1;
                                end
                            end
                            ModeSat: begin
                                val        <= 9'(PCT_MAX);
                                sat        <= {2'b00, sat_ramp_q};
                                sat_ramp_q <= (sat_ramp_q == 7'(PCT_MAX)) ? 7'd0
                                                                          : sat_ramp_q + 7'd1;
                            end
                            default: ;
                        endcase
                    end
                end
                StIssue: begin
                    state_q    <= StWait;
                    wait_cnt_q <= '0;
                end
                StWait: begin
                    if (wait_cnt_q == 4'(CONV_LAT - 1)) begin
                        state_q   <= StCapture;
                        r         <= conv_r;
                        g         <= conv_g;
                        b         <= conv_b;
                        rgb_valid <= 1'b1;
                        changed   <= ({conv_r, conv_g, conv_b} != {r, g, b});
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 4'd1;
                    end
                end
                StCapture: begin
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
